uart_core: RTL and testbench

- Full-duplex 8N1-style UART with a runtime-programmable baud-tick generator, 16x-oversampling receiver and transmitter, and one FIFO per direction.
- Serves as the serial byte source for the frame-buffer loader; that loader ties rd_uart high and treats each low pulse of rx_empty as a byte strobe.
- The transmit path is complete and independently usable.

---
 rtl/uart_core.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_core (with helper uart_fifo)
//  Description : Full-duplex UART, 16x oversampling on a programmable baud
//                tick, one first-word-fall-through FIFO per direction.
//  Ports       : clk, reset_n           - clock, async active-low reset
//                rx / tx                - serial in / out (idle high)
//                r_data, rd_uart,       - RX FIFO head, pop, empty flag
//                rx_empty
//                w_data, wr_uart,       - TX FIFO data, push, full flag
//                tx_full
//                TIMER_FINAL_VALUE      - baud divisor (tick every N+1 clk)
//  Revision    : 1.0 - initial release
// ============================================================================

module uart_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,     // caller guarantees no push into a full FIFO without a pop
    input  logic [DW-1:0] wdata,
    input  logic          rd_en,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] r_mem [2**AW];
    logic [AW-1:0] r_wptr, r_rptr;
    logic          r_full, r_empty;
    logic          w_do_rd;
    logic [AW-1:0] w_wptr_nxt, w_rptr_nxt;

    assign w_do_rd    = rd_en & ~r_empty;
    assign w_wptr_nxt = r_wptr + AW'(1);
    assign w_rptr_nxt = r_rptr + AW'(1);
    assign rdata      = r_mem[r_rptr];
    assign full       = r_full;
    assign empty      = r_empty;

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            r_mem[r_wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            case ({wr_en, w_do_rd})
                2'b10: begin
                    r_wptr  <= w_wptr_nxt;
                    r_empty <= 1'b0;
                    r_full  <= (w_wptr_nxt == r_rptr);
                end
                2'b01: begin
                    r_rptr  <= w_rptr_nxt;
                    r_full  <= 1'b0;
                    r_empty <= (w_rptr_nxt == r_wptr);
                end
                2'b11: begin
                    r_wptr <= w_wptr_nxt;
                    r_rptr <= w_rptr_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

module uart_core #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    output logic [DBIT-1:0] r_data,
    input  logic            rd_uart,
    output logic            rx_empty,
    input  logic [DBIT-1:0] w_data,
    input  logic            wr_uart,
    output logic            tx_full,
    output logic            tx,
    input  logic [10:0]     TIMER_FINAL_VALUE
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [4:0]    c_sb_last  = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] c_bit_last = NW'(DBIT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // ---------------- baud tick ----------------
    logic [10:0] r_tmr;
    logic        w_s_tick;

    assign w_s_tick = (r_tmr == TIMER_FINAL_VALUE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_tmr <= '0;
        else          r_tmr <= w_s_tick ? 11'd0 : r_tmr + 11'd1;
    end

    // ---------------- receiver ----------------
    logic            r_rx_meta, r_rx_sync;
    state_t          r_rx_state;
    logic [4:0]      r_rx_s;
    logic [NW-1:0]   r_rx_n;
    logic [DBIT-1:0] r_rx_b;
    logic            r_rx_done;
    logic            w_rx_full, w_rx_push;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= ST_IDLE;
            r_rx_s     <= '0;
            r_rx_n     <= '0;
            r_rx_b     <= '0;
            r_rx_done  <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            case (r_rx_state)
                ST_IDLE: if (!r_rx_sync) begin
                    r_rx_state <= ST_START;
                    r_rx_s     <= '0;
                end
                ST_START: if (w_s_tick) begin
                    // Middle of the start bit: a high line here was a glitch.
                    if (r_rx_s == 5'd7) begin
                        r_rx_s     <= '0;
                        r_rx_n     <= '0;
                        r_rx_state <= r_rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        r_rx_s <= r_rx_s + 5'd1;
                    end
                end
                ST_DATA: if (w_s_tick) begin
                    if (r_rx_s == 5'd15) begin
                        r_rx_s <= '0;
                        r_rx_b <= {r_rx_sync, r_rx_b[DBIT-1:1]};
                        if (r_rx_n == c_bit_last) r_rx_state <= ST_STOP;
                        else                      r_rx_n <= r_rx_n + NW'(1);
                    end else begin
                        r_rx_s <= r_rx_s + 5'd1;
                    end
                end
                default: if (w_s_tick) begin
                    // Stop-bit level is not checked; the frame is always kept.
                    if (r_rx_s == c_sb_last) begin
                        r_rx_state <= ST_IDLE;
                        r_rx_done  <= 1'b1;
                    end else begin
                        r_rx_s <= r_rx_s + 5'd1;
                    end
                end
            endcase
        end
    end

    // A full FIFO still takes the byte when a pop happens in the same cycle.
    assign w_rx_push = r_rx_done & (~w_rx_full | (rd_uart & ~rx_empty));

    uart_fifo #(.DW(DBIT), .AW(ADDR_WIDTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (w_rx_push),
        .wdata   (r_rx_b),
        .rd_en   (rd_uart),
        .rdata   (r_data),
        .full    (w_rx_full),
        .empty   (rx_empty)
    );

    // ---------------- transmitter ----------------
    state_t          r_tx_state;
    logic [4:0]      r_tx_s;
    logic [NW-1:0]   r_tx_n;
    logic [DBIT-1:0] r_tx_b;
    logic            r_tx;
    logic            w_tx_done, w_tx_empty;
    logic [DBIT-1:0] w_tx_head, w_tx_shift;

    assign w_tx_shift = r_tx_b >> 1;
    // The head stays queued until its stop bit completes, then is popped.
    assign w_tx_done  = (r_tx_state == ST_STOP) & w_s_tick & (r_tx_s == c_sb_last);
    assign tx         = r_tx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_s     <= '0;
            r_tx_n     <= '0;
            r_tx_b     <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_tx_empty) begin
                        r_tx_state <= ST_START;
                        r_tx_s     <= '0;
                        r_tx_b     <= w_tx_head;
                        r_tx       <= 1'b0;
                    end
                end
                ST_START: if (w_s_tick) begin
                    if (r_tx_s == 5'd15) begin
                        r_tx_state <= ST_DATA;
                        r_tx_s     <= '0;
                        r_tx_n     <= '0;
                        r_tx       <= r_tx_b[0];
                    end else begin
                        r_tx_s <= r_tx_s + 5'd1;
                    end
                end
                ST_DATA: if (w_s_tick) begin
                    if (r_tx_s == 5'd15) begin
                        r_tx_s <= '0;
                        r_tx_b <= w_tx_shift;
                        if (r_tx_n == c_bit_last) begin
                            r_tx_state <= ST_STOP;
                            r_tx       <= 1'b1;
                        end else begin
                            r_tx_n <= r_tx_n + NW'(1);
                            r_tx   <= w_tx_shift[0];
                        end
                    end else begin
                        r_tx_s <= r_tx_s + 5'd1;
                    end
                end
                default: if (w_s_tick) begin
                    if (r_tx_s == c_sb_last) r_tx_state <= ST_IDLE;
                    else                     r_tx_s <= r_tx_s + 5'd1;
                end
            endcase
        end
    end

    uart_fifo #(.DW(DBIT), .AW(ADDR_WIDTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_uart & ~tx_full),
        .wdata   (w_data),
        .rd_en   (w_tx_done),
        .rdata   (w_tx_head),
        .full    (tx_full),
        .empty   (w_tx_empty)
    );
endmodule

`default_nettype wire

// File: tb/tb_uart_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_core
//  Description : Scoreboard bench for uart_core. Expected bytes are queued at
//                stimulus time; independent monitors decode tx and observe
//                RX FIFO pops, comparing against the queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_core;
    localparam int TFV      = 4;
    localparam int BIT_CLKS = 16 * (TFV + 1);

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic        rd_uart = 1'b0;
    logic        wr_uart = 1'b0;
    logic [7:0]  w_data = 8'h00;
    logic [10:0] tfv = 11'(TFV);
    wire  [7:0]  r_data;
    wire         rx_empty, tx_full, tx;

    uart_core #(.DBIT(8), .SB_TICK(16), .ADDR_WIDTH(4)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .rx                (rx),
        .r_data            (r_data),
        .rd_uart           (rd_uart),
        .rx_empty          (rx_empty),
        .w_data            (w_data),
        .wr_uart           (wr_uart),
        .tx_full           (tx_full),
        .tx                (tx),
        .TIMER_FINAL_VALUE (tfv)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] mon_b;
    logic [7:0] burst[18];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference serial frame: start 0, eight data bits LSB first, stop 1.
    task automatic send_rx(input logic [7:0] b);
        rx = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(BIT_CLKS);
        end
        rx = 1'b1;
        step(BIT_CLKS);
    endtask

    task automatic push_tx(input logic [7:0] b);
        w_data  = b;
        wr_uart = 1'b1;
        step(1);
        wr_uart = 1'b0;
    endtask

    task automatic wait_tx_drain(input int budget);
        int t = 0;
        while (tx_exp.size() != 0 && t < budget) begin
            step(1);
            t++;
        end
        check("tx_drain_remaining", tx_exp.size(), 0);
    endtask

    // RX monitor: every accepted pop must match the oldest expected byte.
    always @(negedge clk) begin
        if (reset_n && rd_uart && !rx_empty) begin
            if (rx_exp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rx_unexpected: got 0x%0h, expected no byte", r_data);
            end else begin
                check("rx_byte", r_data, rx_exp.pop_front());
            end
        end
    end

    // TX monitor: a UART receiver sampling each bit at its middle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && tx == 1'b0) begin
                repeat (BIT_CLKS / 2) @(negedge clk);
                check("tx_start_bit", tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    mon_b[i] = tx;
                end
                repeat (BIT_CLKS) @(negedge clk);
                check("tx_stop_bit", tx, 1);
                if (tx_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_unexpected: got 0x%0h, expected no byte", mon_b);
                end else begin
                    check("tx_byte", mon_b, tx_exp.pop_front());
                end
            end
        end
    end

    initial begin
        int last;
        int t;
        logic [7:0] b;

        // Reset state
        step(3);
        check("reset_tx", tx, 1);
        check("reset_rx_empty", rx_empty, 1);
        check("reset_tx_full", tx_full, 0);
        reset_n = 1'b1;
        step(2);

        // Tick period with divisor 4
        last = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dut.w_s_tick) begin
                if (last >= 0) check("tick_period", c - last, TFV + 1);
                last = c;
            end
        end
        check("tick_seen", int'(last >= 0), 1);

        // Divisor 0 gives a tick every cycle (after the counter wraps)
        step(1);
        tfv = 11'd0;
        t = 0;
        while (!dut.w_s_tick && t < 3000) begin
            @(negedge clk);
            t++;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("tick_every_cycle", dut.w_s_tick, 1);
        end
        step(1);
        tfv = 11'(TFV);
        step(20);

        // Transmit 0xA5 plus a few random bytes
        tx_exp.push_back(8'hA5);
        push_tx(8'hA5);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            tx_exp.push_back(b);
            push_tx(b);
        end
        wait_tx_drain(5000);
        step(100);

        // Receive 0x3C without reading, then pop once
        rx_exp.push_back(8'h3C);
        send_rx(8'h3C);
        t = 0;
        while (rx_empty && t < 400) begin
            step(1);
            t++;
        end
        check("rx_empty_after_frame", rx_empty, 0);
        check("rx_head_3c", r_data, 8'h3C);
        rd_uart = 1'b1;
        step(1);
        rd_uart = 1'b0;
        check("rx_empty_after_pop", rx_empty, 1);

        // Continuous reading: 0x12, 0x34 and random bytes
        rd_uart = 1'b1;
        rx_exp.push_back(8'h12);
        send_rx(8'h12);
        rx_exp.push_back(8'h34);
        send_rx(8'h34);
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom_range(0, 255));
            rx_exp.push_back(b);
            send_rx(b);
        end
        step(200);
        check("rx_stream_remaining", rx_exp.size(), 0);
        check("rx_stream_empty", rx_empty, 1);
        rd_uart = 1'b0;

        // TX FIFO fill: 17 back-to-back pushes, the 17th is dropped
        for (int i = 0; i < 17; i++) burst[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 17; i++) begin
            w_data  = burst[i];
            wr_uart = 1'b1;
            if (i < 16) tx_exp.push_back(burst[i]);
            step(1);
            if (i == 14) check("tx_full_after_15", tx_full, 0);
            if (i == 15) check("tx_full_after_16", tx_full, 1);
        end
        wr_uart = 1'b0;
        wait_tx_drain(16 * 900 + 2000);
        check("tx_full_after_drain", tx_full, 0);
        step(200);

        // Start-bit glitch of 3 ticks is rejected
        rx = 1'b0;
        step(3 * (TFV + 1));
        rx = 1'b1;
        step(1000);
        check("glitch_rx_empty", rx_empty, 1);

        // RX overflow: 18 frames, only the first 16 are kept
        for (int i = 0; i < 18; i++) burst[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 18; i++) begin
            if (i < 16) rx_exp.push_back(burst[i]);
            send_rx(burst[i]);
        end
        step(200);
        check("overflow_rx_not_empty", rx_empty, 0);
        rd_uart = 1'b1;
        step(40);
        rd_uart = 1'b0;
        check("overflow_remaining", rx_exp.size(), 0);
        check("overflow_drained", rx_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
